fpu_div_issue: RTL

Core-side initiator for the FSM floating-point divider (start/busy/done interface). Accepts FDIV.S requests from the RV32IMF execute stage over valid/ready and resolves IEEE-754 special operands locally. For normal operands it pulses the divider's start, waits for done and captures the quotient. It returns the result with its destination register over a valid/ready writeback channel, and supports pipeline flush.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_div_special.sv | 51 +++++
 rtl/fpu_div_issue.sv | 115 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FSM encoding for the divide issue unit, IEEE-754 single field widths and constants.
package fpu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF   = 32'h7F800000;
  localparam logic [31:0] NEG_INF   = 32'hFF800000;

  function automatic logic [31:0] signed_inf(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fpu_div_special.sv
// Combinational FDIV.S operand classifier: resolves NaN/inf/zero operands without the divider.
// Denormals are flushed to zero before classification.
module fpu_div_special #(
  parameter logic [31:0] NAN_VAL = fpu_pkg::CANON_NAN
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_result,
  output logic        dz,
  output logic        nv
);
  import fpu_pkg::*;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign;

  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign ma     = a[22:0];
  assign mb     = b[22:0];
  assign nan_a  = (ea == '1) && (ma != '0);
  assign nan_b  = (eb == '1) && (mb != '0);
  assign inf_a  = (ea == '1) && (ma == '0);
  assign inf_b  = (eb == '1) && (mb == '0);
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign sign   = a[31] ^ b[31];

  // Priority order matters: inf/0 yields a plain signed inf, not a divide-by-zero.
  always_comb begin
    is_special     = 1'b1;
    special_result = NAN_VAL;
    dz             = 1'b0;
    nv             = 1'b0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      nv = 1'b1;
    end else if (inf_a) begin
      special_result = signed_inf(sign);
    end else if (zero_b) begin
      special_result = signed_inf(sign);
      dz             = 1'b1;
    end else if (zero_a || inf_b) begin
      special_result = {sign, 31'b0};
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_div_issue.sv
// FDIV.S issue unit: accepts requests, resolves special operands locally and drives the FSM divider.
// Optional watchdog on the divider wait: define FPU_DIV_TIMEOUT_EN.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid never depends on ready.
module fpu_div_issue #(
  parameter int          RD_W           = 5,
  parameter logic [31:0] CANON_NAN      = fpu_pkg::CANON_NAN,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic            div_start,
  output logic [31:0]     div_N1,
  output logic [31:0]     div_N2,
  input  logic            div_busy,
  input  logic            div_done,
  input  logic [31:0]     div_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_dz,
  output logic            resp_nv,
  output logic [2:0]      state_dbg
);
  import fpu_pkg::*;

  logic [2:0]      state, nxt;
  logic            up;
  logic [31:0]     a_q, b_q;
  logic [RD_W-1:0] rd_q;
  logic            sp_is, sp_dz, sp_nv, accept, tmo;
  logic [31:0]     sp_res;

  fpu_div_special #(.NAN_VAL(CANON_NAN)) u_special (
    .a(req_a), .b(req_b), .is_special(sp_is), .special_result(sp_res), .dz(sp_dz), .nv(sp_nv)
  );

  // up keeps req_ready low while reset is asserted even though the state reads IDLE.
  assign req_ready  = up && (state == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign div_start  = (state == ST_LAUNCH) && !div_busy && !flush;
  assign resp_valid = (state == ST_RESP) && !flush;
  assign div_N1     = a_q;
  assign div_N2     = b_q;
  assign resp_rd    = rd_q;
  assign state_dbg  = state;

`ifdef FPU_DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restarts from zero whenever the FSM changes state, so WAIT and DRAIN each get a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (state != nxt) cnt <= '0;
    else if ((state == ST_WAIT) || (state == ST_DRAIN)) cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // flush is checked first so it wins over div_done and resp_ready.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (accept) nxt = sp_is ? ST_RESP : ST_LAUNCH;
      ST_LAUNCH: if (flush) nxt = ST_IDLE; else if (!div_busy) nxt = ST_WAIT;
      ST_WAIT:   if (flush) nxt = ST_DRAIN; else if (div_done || tmo) nxt = ST_RESP;
      ST_DRAIN:  if (div_done || tmo) nxt = ST_IDLE;
      ST_RESP:   if (flush || resp_ready) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      up        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      resp_data <= '0;
      resp_dz   <= 1'b0;
      resp_nv   <= 1'b0;
    end else begin
      state <= nxt;
      up    <= 1'b1;
      if ((state == ST_IDLE) && accept) begin
        a_q       <= req_a;
        b_q       <= req_b;
        rd_q      <= req_rd;
        resp_data <= sp_res;
        resp_dz   <= sp_dz;
        resp_nv   <= sp_nv;
      end else if ((state == ST_WAIT) && !flush && div_done) begin
        resp_data <= div_result;
        resp_dz   <= 1'b0;
        resp_nv   <= 1'b0;
      end else if ((state == ST_WAIT) && !flush && tmo) begin
        resp_data <= CANON_NAN;
        resp_dz   <= 1'b0;
        resp_nv   <= 1'b1;
      end
    end
  end

endmodule
